// File: rtl/vga_image_window.sv
// vga_image_window
// Programmable-timing VGA sync generator that overlays an IMG_W x IMG_H image,
// upscaled by 2^SCALE_LOG2, read from one of N_BANKS external ROMs. Window
// position, bank and vertical flip are captured once per frame. Sync, DE and
// the in-window decision travel down a delay line so they reach the output
// register in the same clock as the ROM data for that pixel.
module vga_image_window #(
    parameter int          H_SYNC     = 136,
    parameter int          H_BACK     = 160,
    parameter int          H_DISP     = 1024,
    parameter int          H_FRONT    = 24,
    parameter int          V_SYNC     = 6,
    parameter int          V_BACK     = 29,
    parameter int          V_DISP     = 768,
    parameter int          V_FRONT    = 3,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int          IMG_W      = 256,
    parameter int          IMG_H      = 184,
    parameter int          SCALE_LOG2 = 1,
    parameter int          N_BANKS    = 4,
    parameter int          ROM_LAT    = 1,
    parameter logic [11:0] BG_COLOR   = 12'hFFF,
    parameter int          AW         = 16,
    localparam int         BW         = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        x_pos,
    input  logic [10:0]        y_pos,
    input  logic [BW-1:0]      bank_sel,
    input  logic               flip_v,
    output logic [AW-1:0]      rom_addr,
    output logic [N_BANKS-1:0] rom_en,
    input  logic [11:0]        rom_data,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic               frame_start
);

    // Coordinate width: wide enough for the counters and for an 11-bit window
    // edge plus the scaled image size, so window bounds never wrap.
    localparam int CW = 16;

    localparam logic [CW-1:0] H_LAST     = CW'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [CW-1:0] H_SYNC_C   = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_C   = CW'(V_SYNC);
    localparam logic [CW-1:0] H_OFF      = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] V_OFF      = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] H_END      = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] V_END      = CW'(V_SYNC + V_BACK + V_DISP);
    localparam logic [CW-1:0] WIN_W      = CW'(IMG_W << SCALE_LOG2);
    localparam logic [CW-1:0] WIN_H      = CW'(IMG_H << SCALE_LOG2);
    localparam logic [CW-1:0] IMG_H_LAST = CW'(IMG_H - 1);

    logic               run;
    logic [CW-1:0]      h_cnt;
    logic [CW-1:0]      v_cnt;
    logic               frame_end;

    logic [CW-1:0]      xw_q;
    logic [CW-1:0]      yw_q;
    logic [BW-1:0]      bank_q;
    logic               flip_q;

    logic [CW-1:0]      x;
    logic [CW-1:0]      y;
    logic [CW-1:0]      col;
    logic [CW-1:0]      row;
    logic [AW-1:0]      addr0;
    logic               hs0;
    logic               vs0;
    logic               de0;
    logic               win0;

    logic [ROM_LAT:0]   hs_d;
    logic [ROM_LAT:0]   vs_d;
    logic [ROM_LAT:0]   de_d;
    logic [ROM_LAT:0]   win_d;
    logic [11:0]        pix;

    // Held low during reset and set on the first clock after release; the
    // counters stay at h=v=0 for that first clock so the frame starts cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign frame_end   = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);

    // Window shadows load on the last pixel of a frame so the whole next frame
    // uses one consistent set; an out-of-range bank request keeps the old bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xw_q   <= '0;
            yw_q   <= '0;
            bank_q <= '0;
            flip_q <= 1'b0;
        end else if (frame_end) begin
            xw_q   <= CW'(x_pos);
            yw_q   <= CW'(y_pos);
            flip_q <= flip_v;
            if (32'(bank_sel) < N_BANKS) bank_q <= bank_sel;
        end
    end

    // Pixel classification and source-image addressing for the current count.
    always_comb begin
        hs0   = 1'b0;
        vs0   = 1'b0;
        de0   = 1'b0;
        win0  = 1'b0;
        x     = h_cnt - H_OFF;
        y     = v_cnt - V_OFF;
        col   = '0;
        row   = '0;
        addr0 = '0;
        if (run) begin
            hs0  = (h_cnt < H_SYNC_C);
            vs0  = (v_cnt < V_SYNC_C);
            de0  = (h_cnt >= H_OFF) && (h_cnt < H_END) &&
                   (v_cnt >= V_OFF) && (v_cnt < V_END);
            win0 = de0 && (x >= xw_q) && (x < xw_q + WIN_W) &&
                         (y >= yw_q) && (y < yw_q + WIN_H);
        end
        if (win0) begin
            col = (x - xw_q) >> SCALE_LOG2;
            row = (y - yw_q) >> SCALE_LOG2;
            if (flip_q) row = IMG_H_LAST - row;
            addr0 = AW'(32'(row) * IMG_W + 32'(col));
        end
    end

    // Registered ROM request plus the sync/DE/window delay line that keeps
    // these flags in step with the returning ROM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr <= '0;
            rom_en   <= '0;
            hs_d     <= '0;
            vs_d     <= '0;
            de_d     <= '0;
            win_d    <= '0;
        end else begin
            rom_addr <= win0 ? addr0 : '0;
            rom_en   <= win0 ? (N_BANKS'(1) << bank_q) : '0;
            hs_d     <= {hs_d[ROM_LAT-1:0],  hs0};
            vs_d     <= {vs_d[ROM_LAT-1:0],  vs0};
            de_d     <= {de_d[ROM_LAT-1:0],  de0};
            win_d    <= {win_d[ROM_LAT-1:0], win0};
        end
    end

    // Colour source: image inside the window, background elsewhere in the
    // active area, black during blanking.
    always_comb begin
        pix = 12'h000;
        if (win_d[ROM_LAT])     pix = rom_data;
        else if (de_d[ROM_LAT]) pix = BG_COLOR;
    end

    // Output register; sync flags are converted to the configured polarity here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
            vga_de <= 1'b0;
        end else begin
            vga_r  <= pix[3:0];
            vga_g  <= pix[7:4];
            vga_b  <= pix[11:8];
            vga_hs <= hs_d[ROM_LAT] ? HS_POL : ~HS_POL;
            vga_vs <= vs_d[ROM_LAT] ? VS_POL : ~VS_POL;
            vga_de <= de_d[ROM_LAT];
        end
    end

endmodule

// File: tb/tb_vga_image_window.sv
// tb_vga_image_window
// Scaled-down timing (50 x 36 clocks per frame) so many frames fit in a short
// run. A producer computes, for every pixel count, the expected ROM request and
// the expected output word straight from the display rules and queues them with
// the clock at which they are due; a monitor pops and compares each clock.
module tb_vga_image_window;

    localparam int H_SYNC = 4, H_BACK = 3, H_DISP = 40, H_FRONT = 3;
    localparam int V_SYNC = 2, V_BACK = 2, V_DISP = 30, V_FRONT = 2;
    localparam int HT = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int FRAME = HT * VT;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;
    localparam int IMG_W = 8, IMG_H = 6, SCALE_LOG2 = 1, SC = 2;
    localparam int N_BANKS = 3, ROM_LAT = 2, AW = 8, BW = 2;
    localparam int LAT = 2 + ROM_LAT;
    localparam logic [11:0] BG = 12'h6A9;

    typedef struct {
        int due;
        int val;
    } item_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [10:0]        x_pos = '0;
    logic [10:0]        y_pos = '0;
    logic [BW-1:0]      bank_sel = '0;
    logic               flip_v = 1'b0;
    logic [AW-1:0]      rom_addr;
    logic [N_BANKS-1:0] rom_en;
    logic [11:0]        rom_data;
    logic [3:0]         vga_r, vga_g, vga_b;
    logic               vga_hs, vga_vs, vga_de;
    logic               frame_start;

    logic [11:0]        rom_pipe [ROM_LAT];
    int                 cyc = -1;
    int                 checks = 0;
    int                 errors = 0;
    item_t              pix_q[$];
    item_t              mem_q[$];
    item_t              fs_q[$];

    int sh_x = 0, sh_y = 0, sh_b = 0, sh_f = 0;
    int m_h, m_v, m_x, m_y, m_col, m_row, m_addr, m_colour, m_pix;
    bit m_act, m_win;
    int de_run = 0;

    vga_image_window #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT),
        .HS_POL(HS_POL), .VS_POL(VS_POL),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_LOG2(SCALE_LOG2),
        .N_BANKS(N_BANKS), .ROM_LAT(ROM_LAT), .BG_COLOR(BG), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .x_pos(x_pos), .y_pos(y_pos), .bank_sel(bank_sel), .flip_v(flip_v),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Contents of ROM 'bank' at 'addr'; distinct for every address and bank.
    function automatic logic [11:0] romVal(input int addr, input int bank);
        return 12'((addr * 37 + bank * 1365 + 11) % 4096);
    endfunction

    function automatic int decodeBank(input logic [N_BANKS-1:0] en);
        for (int i = 0; i < N_BANKS; i++) if (en[i]) return i;
        return -1;
    endfunction

    function automatic item_t mkItem(input int due, input int val);
        item_t it;
        it.due = due;
        it.val = val;
        return it;
    endfunction

    function automatic int idlePix();
        return (int'(!HS_POL) << 14) | (int'(!VS_POL) << 13);
    endfunction

    // External ROM bank model with ROM_LAT clocks of latency.
    always @(posedge clk) begin
        rom_pipe[0] <= (decodeBank(rom_en) < 0) ? 12'h3C3 :
                       romVal(int'(rom_addr), decodeBank(rom_en));
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    // Bench pixel index: 0 on the clock following the first edge after release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= -1;
        else      cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic checkQueue(input int which, input string name, input int actual);
        item_t it;
        bit    have;
        have = 1'b0;
        case (which)
            0: if (pix_q.size() > 0 && pix_q[0].due == cyc) begin it = pix_q.pop_front(); have = 1'b1; end
            1: if (mem_q.size() > 0 && mem_q[0].due == cyc) begin it = mem_q.pop_front(); have = 1'b1; end
            default: if (fs_q.size() > 0 && fs_q[0].due == cyc) begin it = fs_q.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
            checkOutput(name, actual, it.val);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected entry missing", name, cyc, actual);
        end
    endtask

    // Producer: expected behaviour of pixel 'cyc' derived from the display rules.
    always @(negedge clk) begin
        if (!rst) begin
            sh_x = 0; sh_y = 0; sh_b = 0; sh_f = 0;
            pix_q.delete();
            mem_q.delete();
            fs_q.delete();
        end else if (cyc >= 0) begin
            if (cyc == 0) begin
                for (int k = 0; k < LAT; k++) pix_q.push_back(mkItem(k, idlePix()));
                mem_q.push_back(mkItem(0, 0));
            end
            m_h   = cyc % HT;
            m_v   = (cyc / HT) % VT;
            m_x   = m_h - (H_SYNC + H_BACK);
            m_y   = m_v - (V_SYNC + V_BACK);
            m_act = (m_x >= 0) && (m_x < H_DISP) && (m_y >= 0) && (m_y < V_DISP);
            m_win = m_act && (m_x >= sh_x) && (m_x < sh_x + IMG_W * SC) &&
                             (m_y >= sh_y) && (m_y < sh_y + IMG_H * SC);
            m_addr   = 0;
            m_colour = 0;
            if (m_win) begin
                m_col = (m_x - sh_x) / SC;
                m_row = (m_y - sh_y) / SC;
                if (sh_f != 0) m_row = IMG_H - 1 - m_row;
                m_addr   = m_row * IMG_W + m_col;
                m_colour = int'(romVal(m_addr, sh_b));
            end else if (m_act) begin
                m_colour = int'(BG);
            end
            m_pix = (((m_h < H_SYNC) ? int'(HS_POL) : int'(!HS_POL)) << 14) |
                    (((m_v < V_SYNC) ? int'(VS_POL) : int'(!VS_POL)) << 13) |
                    ((m_act ? 1 : 0) << 12) | m_colour;
            pix_q.push_back(mkItem(cyc + LAT, m_pix));
            mem_q.push_back(mkItem(cyc + 1, m_win ? (((1 << sh_b) << AW) | m_addr) : 0));
            fs_q.push_back(mkItem(cyc, (m_h == 0 && m_v == 0) ? 1 : 0));
            if (m_h == HT - 1 && m_v == VT - 1) begin
                sh_x = int'(x_pos);
                sh_y = int'(y_pos);
                sh_f = int'(flip_v);
                if (int'(bank_sel) < N_BANKS) sh_b = int'(bank_sel);
            end
        end
    end

    // Monitor: compares DUT outputs with the queued expectations every clock.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            de_run = 0;
        end else if (cyc >= 0) begin
            checkQueue(0, "pixel", int'({vga_hs, vga_vs, vga_de, vga_b, vga_g, vga_r}));
            checkQueue(1, "rom_req", int'({rom_en, rom_addr}));
            checkQueue(2, "frame_start", int'(frame_start));
            if (vga_de) begin
                de_run++;
            end else if (de_run > 0) begin
                checkOutput("de_run", de_run, H_DISP);
                de_run = 0;
            end
        end
    end

    task automatic applyStimulus(input int xp, input int yp, input int bs, input int fv);
        x_pos    = 11'(xp);
        y_pos    = 11'(yp);
        bank_sel = BW'(bs);
        flip_v   = 1'(fv);
    endtask

    task automatic checkReset();
        checkOutput("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
        checkOutput("reset_de", int'(vga_de), 0);
        checkOutput("reset_hs", int'(vga_hs), int'(!HS_POL));
        checkOutput("reset_vs", int'(vga_vs), int'(!VS_POL));
        checkOutput("reset_rom_en", int'(rom_en), 0);
        checkOutput("reset_rom_addr", int'(rom_addr), 0);
        checkOutput("reset_frame_start", int'(frame_start), 0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitPhase(input int phase);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while ((cyc % FRAME) != phase && guard <= FRAME + 4);
        if (guard > FRAME + 4) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_phase: got cycle %0d, expected phase %0d", cyc, phase);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checkReset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // Directed window settings, each taking effect one frame after it is applied.
    int set_x[6] = '{8, 8, 30, 12, 12, 2000};
    int set_y[6] = '{4, 4, 22, 10, 10, 5};
    int set_b[6] = '{0, 0, 0, 2, 3, 1};
    int set_f[6] = '{0, 1, 0, 0, 1, 0};

    initial begin
        applyStimulus(8, 4, 0, 0);
        repeat (3) @(posedge clk);
        #1 checkReset();
        @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            waitPhase(FRAME / 2);
            applyStimulus(set_x[i], set_y[i], set_b[i], set_f[i]);
        end

        for (int r = 0; r < 30; r++) begin
            waitCycles($urandom_range(50, 600));
            applyStimulus(($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 45),
                          $urandom_range(0, 33), $urandom_range(0, 3), $urandom_range(0, 1));
        end

        waitPhase(20 * HT + 7);
        doReset();

        for (int i = 0; i < 2; i++) begin
            waitPhase(FRAME / 2);
            applyStimulus(6 + 20 * i, 3 + 15 * i, 1 + i, 1 - i);
        end
        waitPhase(FRAME / 2);
        waitCycles(LAT + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
